// File: rtl/minesweeper_pkg.sv
// Shared constants and types for the minesweeper mine-placement slice:
// board defaults, LFSR taps and the placement FSM state encoding.
package minesweeper_pkg;

  localparam int DEF_ROWS      = 5;
  localparam int DEF_COLS      = 5;
  localparam int DEF_NUM_MINES = 5;
  localparam int CELLS         = DEF_ROWS * DEF_COLS;

  // Taps for x^8+x^6+x^5+x^4+1 on a left-shifting Fibonacci register.
  localparam logic [7:0] LFSR_TAPS  = 8'hB8;
  localparam logic [7:0] LFSR_RESET = 8'h01;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_DRAW  = 3'd2,
    ST_CHECK = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/mine_lfsr.sv
// 8-bit Fibonacci LFSR with seed load (priority over stepping) and a
// zero-seed guard so the register can never lock up at all-zeros.
module mine_lfsr
  import minesweeper_pkg::*;
(
  input  logic       clka,
  input  logic       restart,
  input  logic       load,
  input  logic [7:0] seed,
  output logic [7:0] lfsr
);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of process order.
  always_ff @(posedge clka) begin
    if (!restart) begin
      lfsr <= LFSR_RESET;
    end else if (load) begin
      lfsr <= (seed == 8'h00) ? LFSR_RESET : seed;
    end else begin
      lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/mine_place_ctrl.sv
// Mine placement sequencer: draws LFSR candidates, rejects duplicates and
// out-of-range cells, and builds the mine bitmap. Optional MINE_SAFE_FIRST_EN
// also keeps the cell given on safe_cell (sampled with start) mine-free.
module mine_place_ctrl
  import minesweeper_pkg::*;
#(
  parameter int ROWS      = DEF_ROWS,
  parameter int COLS      = DEF_COLS,
  parameter int NUM_MINES = DEF_NUM_MINES,
  parameter int IDX_W     = 5
) (
  input  logic                   clka,
  input  logic                   restart,
  input  logic                   start,
  input  logic [7:0]             seed,
  input  logic                   seed_load,
  input  logic [IDX_W-1:0]       safe_cell,
  input  logic [IDX_W-1:0]       query_addr,
  output logic                   query_mine,
  output logic [ROWS*COLS-1:0]   mine_map,
  output logic [IDX_W-1:0]       mine_count,
  output logic                   busy,
  output logic                   place_done
);

  localparam int               NCELLS    = ROWS * COLS;
  localparam logic [IDX_W:0]   CELLS_LIM = (IDX_W+1)'(NCELLS);
  localparam logic [IDX_W-1:0] LAST_CNT  = IDX_W'(NUM_MINES - 1);

  state_t           state, state_nx;
  logic [7:0]       lfsr_val;
  logic [IDX_W-1:0] cand_q;
  logic             cand_ok, map_hit, safe_hit, reject, query_ok;
  logic             unused_lfsr;
  logic             can_start;

  mine_lfsr u_lfsr (
    .clka    (clka),
    .restart (restart),
    .load    (seed_load),
    .seed    (seed),
    .lfsr    (lfsr_val)
  );

  // Only the low IDX_W bits form the candidate; the rest just feed the LFSR.
  assign unused_lfsr = ^lfsr_val;
  assign can_start   = start && (state == ST_IDLE || state == ST_DONE);

  assign cand_ok  = {1'b0, cand_q} < CELLS_LIM;
  assign map_hit  = cand_ok && mine_map[cand_q];
  assign query_ok = {1'b0, query_addr} < CELLS_LIM;

`ifdef MINE_SAFE_FIRST_EN
  logic [IDX_W-1:0] safe_q;

  always_ff @(posedge clka) begin
    if (!restart)       safe_q <= '0;
    else if (can_start) safe_q <= safe_cell;
  end

  assign safe_hit = (cand_q == safe_q);
`else
  logic unused_safe;
  assign unused_safe = ^safe_cell;
  assign safe_hit    = 1'b0;
`endif

  assign reject = !cand_ok || map_hit || safe_hit;

  always_ff @(posedge clka) begin
    if (!restart) state <= ST_IDLE;
    else          state <= state_nx;
  end

  // NOTE: next-state defaults to the current state before the case, so no
  // path leaves state_nx unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:  if (can_start) state_nx = ST_CLEAR;
      ST_CLEAR: state_nx = ST_DRAW;
      ST_DRAW:  state_nx = ST_CHECK;
      ST_CHECK: state_nx = reject ? ST_DRAW : ST_WRITE;
      ST_WRITE: state_nx = (mine_count == LAST_CNT) ? ST_DONE : ST_DRAW;
      ST_DONE:  if (can_start) state_nx = ST_CLEAR;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state == ST_CLEAR) || (state == ST_DRAW) ||
                 (state == ST_CHECK) || (state == ST_WRITE);
    place_done = (state == ST_DONE);
  end

  // NOTE: the bitmap is a handful of flops, not a RAM, so it is reset along
  // with everything else and reads as all-clear straight out of reset.
  always_ff @(posedge clka) begin
    if (!restart) begin
      mine_map   <= '0;
      mine_count <= '0;
      cand_q     <= '0;
      query_mine <= 1'b0;
    end else begin
      query_mine <= query_ok && mine_map[query_addr];
      case (state)
        ST_CLEAR: begin
          mine_map   <= '0;
          mine_count <= '0;
        end
        ST_DRAW:  cand_q <= lfsr_val[IDX_W-1:0];
        ST_WRITE: begin
          mine_map[cand_q] <= 1'b1;
          mine_count       <= mine_count + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mine_place_ctrl.sv
// Self-checking bench for mine_place_ctrl: a reference LFSR history plus a
// draw/accept model predicts each bitmap and the edge where DONE is reached.
module tb_mine_place_ctrl;
  import minesweeper_pkg::*;

  localparam int IDX_W  = 5;
  localparam int NCELLS = 25;
  localparam int HIST   = 65536;
`ifdef MINE_SAFE_FIRST_EN
  localparam int NM      = 24;
  localparam bit SAFE_EN = 1'b1;
`else
  localparam int NM      = 5;
  localparam bit SAFE_EN = 1'b0;
`endif

  logic              clka = 1'b0;
  logic              restart, start, seed_load;
  logic [7:0]        seed;
  logic [IDX_W-1:0]  safe_cell, query_addr;
  logic              query_mine, busy, place_done;
  logic [NCELLS-1:0] mine_map;
  logic [IDX_W-1:0]  mine_count;

  int n_checks = 0;
  int n_pass   = 0;

  mine_place_ctrl #(.ROWS(5), .COLS(5), .NUM_MINES(NM), .IDX_W(IDX_W)) dut (
    .clka       (clka),
    .restart    (restart),
    .start      (start),
    .seed       (seed),
    .seed_load  (seed_load),
    .safe_cell  (safe_cell),
    .query_addr (query_addr),
    .query_mine (query_mine),
    .mine_map   (mine_map),
    .mine_count (mine_count),
    .busy       (busy),
    .place_done (place_done)
  );

  always #5 clka = ~clka;

  // Reference LFSR; hist[e] holds the value present just before edge e.
  logic [7:0] m_lfsr = 8'h01;
  int         cyc    = 0;
  logic [7:0] hist [HIST];

  always @(posedge clka) begin
    hist[cyc % HIST] <= m_lfsr;
    cyc              <= cyc + 1;
    if (!restart)       m_lfsr <= 8'h01;
    else if (seed_load) m_lfsr <= (seed == 8'h00) ? 8'h01 : seed;
    else                m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  // Start sampled at edge k: first draw at k+2, a reject costs 2 edges, an
  // accept 3; DONE is entered on the edge after the final accepted draw's WRITE.
  task automatic model_place(input int k, input logic [IDX_W-1:0] safe,
                             output logic [NCELLS-1:0] map, output int done_edge);
    int e = k + 2;
    int cnt = 0;
    int guard = 0;
    logic [IDX_W-1:0] c;
    map = '0;
    done_edge = -1;
    while (cnt < NM && guard < 20000) begin
      c = hist[e % HIST][IDX_W-1:0];
      if (int'(c) < NCELLS && !map[c] && !(SAFE_EN && c == safe)) begin
        map[c] = 1'b1;
        cnt++;
        if (cnt == NM) done_edge = e + 2;
        e += 3;
      end else begin
        e += 2;
      end
      guard++;
    end
  endtask

  task automatic run_place(input string tag, input logic [7:0] sd,
                           input logic [IDX_W-1:0] sc, input bit extra_start,
                           output logic [NCELLS-1:0] got_map,
                           output logic [NCELLS-1:0] exp_map);
    int k, waited, done_at, exp_done;
    @(negedge clka);
    seed = sd; seed_load = 1'b1; safe_cell = sc;
    @(negedge clka);
    seed_load = 1'b0; start = 1'b1; k = cyc;
    @(negedge clka);
    start = 1'b0;
    safe_cell = IDX_W'($urandom);
    n_checks++;
    if (busy !== 1'b1 || place_done !== 1'b0)
      $display("FAIL %s_busy: busy=%b place_done=%b, expected busy=1 place_done=0", tag, busy, place_done);
    else n_pass++;
    if (extra_start) begin
      @(negedge clka); start = 1'b1;
      @(negedge clka); start = 1'b0;
    end
    waited = 0;
    while (!place_done && waited < 3000) begin
      @(negedge clka);
      waited++;
    end
    done_at = cyc - 1;
    model_place(k, sc, exp_map, exp_done);
    got_map = mine_map;
    n_checks++;
    if (place_done !== 1'b1) begin
      $display("FAIL %s_timeout: place_done=%b after %0d cycles, expected 1", tag, place_done, waited);
      return;
    end else n_pass++;
    n_checks++;
    if (mine_map !== exp_map)
      $display("FAIL %s_map: got %h expected %h", tag, mine_map, exp_map);
    else n_pass++;
    n_checks++;
    if (mine_count !== IDX_W'(NM) || $countones(mine_map) != NM)
      $display("FAIL %s_count: mine_count=%0d popcount=%0d expected %0d", tag, mine_count, $countones(mine_map), NM);
    else n_pass++;
    n_checks++;
    if (done_at !== exp_done)
      $display("FAIL %s_latency: done at edge %0d expected edge %0d (start edge %0d)", tag, done_at, exp_done, k);
    else n_pass++;
  endtask

  task automatic test_reset();
    restart = 1'b0;
    repeat (2) @(negedge clka);
    n_checks++;
    if (mine_map !== '0 || mine_count !== '0 || busy !== 1'b0 || place_done !== 1'b0 || query_mine !== 1'b0)
      $display("FAIL reset_outputs: map=%h count=%0d busy=%b done=%b q=%b, expected all 0", mine_map, mine_count, busy, place_done, query_mine);
    else n_pass++;
    n_checks++;
    if (dut.u_lfsr.lfsr !== 8'h01)
      $display("FAIL reset_lfsr: got %h expected 01", dut.u_lfsr.lfsr);
    else n_pass++;
    restart = 1'b1;
  endtask

  task automatic test_seed();
    @(negedge clka); seed = 8'h00; seed_load = 1'b1;
    @(negedge clka); seed_load = 1'b0;
    n_checks++;
    if (dut.u_lfsr.lfsr !== 8'h01) $display("FAIL seed_zero: got %h expected 01", dut.u_lfsr.lfsr);
    else n_pass++;
    seed = 8'h5A; seed_load = 1'b1;
    @(negedge clka); seed_load = 1'b0;
    n_checks++;
    if (dut.u_lfsr.lfsr !== 8'h5A) $display("FAIL seed_5a: got %h expected 5a", dut.u_lfsr.lfsr);
    else n_pass++;
    repeat (20) @(negedge clka);
    n_checks++;
    if (dut.u_lfsr.lfsr !== m_lfsr) $display("FAIL lfsr_step: got %h expected %h", dut.u_lfsr.lfsr, m_lfsr);
    else n_pass++;
    n_checks++;
    if (mine_map !== '0 || place_done !== 1'b0)
      $display("FAIL seed_no_start: map=%h done=%b expected 0/0", mine_map, place_done);
    else n_pass++;
  endtask

  task automatic test_determinism(output logic [NCELLS-1:0] last_exp);
    logic [NCELLS-1:0] got_a, exp_a, got_b, exp_b;
    run_place("det_a", 8'hA3, 5'd12, 1'b0, got_a, exp_a);
    run_place("det_b", 8'hA3, 5'd12, 1'b1, got_b, exp_b);
    n_checks++;
    if (got_a !== got_b) $display("FAIL determinism: run b %h run a %h", got_b, got_a);
    else n_pass++;
    last_exp = exp_b;
  endtask

  task automatic test_query(input logic [NCELLS-1:0] exp_map);
    logic exp_bit;
    for (int a = 0; a < 32; a++) begin
      @(negedge clka); query_addr = IDX_W'(a);
      @(negedge clka);
      exp_bit = (a < NCELLS) ? exp_map[a] : 1'b0;
      n_checks++;
      if (query_mine !== exp_bit) $display("FAIL query_%0d: got %b expected %b", a, query_mine, exp_bit);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [NCELLS-1:0] got, exp;
    run_place("b2b_1", 8'h3C, 5'd12, 1'b0, got, exp);
    run_place("b2b_2", 8'hC7, 5'd12, 1'b0, got, exp);
  endtask

  task automatic test_reset_mid_write();
    int waited = 0;
    @(negedge clka); seed = 8'h77; seed_load = 1'b1;
    @(negedge clka); seed_load = 1'b0; start = 1'b1;
    @(negedge clka); start = 1'b0;
    while (dut.state != ST_WRITE && waited < 500) begin
      @(negedge clka);
      waited++;
    end
    n_checks++;
    if (dut.state != ST_WRITE) $display("FAIL rst_reach_write: WRITE not reached in %0d cycles", waited);
    else n_pass++;
    restart = 1'b0;
    repeat (2) @(negedge clka);
    restart = 1'b1;
    n_checks++;
    if (dut.state != ST_IDLE || mine_map !== '0 || mine_count !== '0 || place_done !== 1'b0 || busy !== 1'b0)
      $display("FAIL rst_mid_write: state=%0d map=%h count=%0d done=%b busy=%b, expected idle/0", dut.state, mine_map, mine_count, place_done, busy);
    else n_pass++;
    repeat (5) @(negedge clka);
    n_checks++;
    if (dut.u_lfsr.lfsr !== m_lfsr || place_done !== 1'b0)
      $display("FAIL rst_after: lfsr=%h done=%b expected lfsr=%h done=0", dut.u_lfsr.lfsr, place_done, m_lfsr);
    else n_pass++;
  endtask

  task automatic test_random_seeds();
    logic [NCELLS-1:0] got, exp, want;
    want = '1;
    want[12] = 1'b0;
    for (int i = 0; i < (SAFE_EN ? 20 : 6); i++) begin
      run_place($sformatf("rnd%0d", i), 8'($urandom), 5'd12, 1'b0, got, exp);
      if (SAFE_EN) begin
        n_checks++;
        if (got !== want) $display("FAIL safe_%0d: got %h expected %h", i, got, want);
        else n_pass++;
      end else begin
        repeat ($urandom_range(0, 7)) @(negedge clka);
      end
    end
  endtask

  initial begin
    logic [NCELLS-1:0] last_exp;
    restart = 1'b0; start = 1'b0; seed = 8'h00; seed_load = 1'b0;
    safe_cell = '0; query_addr = '0;
    test_reset();
    test_seed();
    test_determinism(last_exp);
    test_query(last_exp);
    test_back_to_back();
    test_reset_mid_write();
    test_random_seeds();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mine_place_ctrl.md
Name: mine_place_ctrl

Overview:
- Sequences mine placement on the game board when the main FSM pulses `start` (RNG_PLACE_MINES state).
- Draws candidate cells from an internal LFSR and rejects duplicates and out-of-range cells.
- Builds the mine bitmap and raises `place_done` once exactly NUM_MINES mines are placed.
- The bitmap is read by the decode/ALU datapath through a registered query port and a full bitmap bus.

Parameters:
- ROWS, 5, board rows.
- COLS, 5, board columns.
- NUM_MINES, 5, mines to place; legal range 1..ROWS*COLS-1.
- IDX_W, 5, cell index width; must satisfy 2^IDX_W >= ROWS*COLS.

Ports:
- clka  in  1  single system clock; all logic on posedge.
- restart  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request to (re)place mines.
- seed  in  8  LFSR seed value.
- seed_load  in  1  loads `seed` into the LFSR this cycle.
- safe_cell  in  IDX_W  cell that must stay mine-free (optional feature).
- query_addr  in  IDX_W  cell index to look up.
- query_mine  out  1  registered mine bit for query_addr; 0 if the index is out of range.
- mine_map  out  ROWS*COLS  bitmap, bit i = cell i holds a mine.
- mine_count  out  IDX_W  mines placed so far.
- busy  out  1  high in CLEAR, DRAW, CHECK and WRITE.
- place_done  out  1  level, high in DONE.

Behaviour:
- Reset (restart low at a clka edge):
  - state = IDLE; mine_map, mine_count, query_mine, busy, place_done = 0; lfsr = 8'h01.
  - Reset takes priority over every other input and aborts any placement in progress.
- LFSR:
  - 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, steps every cycle in every state (user timing adds entropy).
  - seed_load has priority over stepping.
  - A seed of 8'h00 loads 8'h01 instead.
  - Candidate cell = lfsr[IDX_W-1:0].
- States: IDLE, CLEAR, DRAW, CHECK, WRITE, DONE.
  - IDLE: start -> CLEAR; otherwise hold.
  - CLEAR (1 cycle): mine_map = 0, mine_count = 0 -> DRAW.
  - DRAW (1 cycle): latch the candidate -> CHECK.
  - CHECK (1 cycle): reject, returning to DRAW, if candidate >= ROWS*COLS, or mine_map[candidate] = 1, or the safe-cell rule hits. Otherwise -> WRITE.
  - WRITE (1 cycle): set mine_map[candidate], increment mine_count. If the new count == NUM_MINES -> DONE, else -> DRAW.
  - DONE: place_done = 1 and held. start -> CLEAR; place_done drops the next cycle.
- start is ignored while busy.
- seed_load is accepted in any state.
- Minimum latency from start to place_done = 1 + 3*NUM_MINES + 1 cycles, i.e. 17 for the defaults.
- mine_map and mine_count are stable and valid only while place_done = 1.
- query_mine:
  - Registered one cycle after query_addr and valid in any state.
  - Returns the mine_map bit as of the previous edge.

Optional Feature:
- Macro: MINE_SAFE_FIRST_EN.
- Defined: CHECK also rejects candidate == safe_cell. safe_cell is sampled on the start cycle, so later changes do not matter. NUM_MINES must be <= ROWS*COLS-1.
- Undefined: the safe_cell port remains but is ignored; any in-range cell may hold a mine.

Decomposition:
- minesweeper_pkg holds:
  - state encodings (3-bit);
  - the LFSR tap constant;
  - the default ROWS/COLS/NUM_MINES;
  - the CELLS = ROWS*COLS constant.
- One sub-module, mine_lfsr: 8-bit LFSR with load, zero-seed guard and step. It is instantiated once.

Test Plan:
- restart low 2 cycles in the middle of WRITE -> next cycle state IDLE, mine_map = 0, mine_count = 0, place_done = 0.
- seed_load with 8'h00, then read lfsr -> 8'h01; with 8'h5A and no start -> mine_map stays 0 and place_done stays 0.
- seed 8'hA3, start pulse -> busy within 1 cycle; place_done within <= 400 cycles; popcount(mine_map) = 5; mine_count = 5; no bit >= 25 set.
- Same seed with start issued at the identical cycle offset twice -> identical mine_map (determinism). A second start while busy -> ignored, and the result is unchanged.
- MINE_SAFE_FIRST_EN, safe_cell = 12, NUM_MINES = 24, 20 random seeds -> mine_map = all ones except bit 12 every run.
- After DONE, query_addr = each of 0..31 -> query_mine equals mine_map[addr] one cycle later, and 0 for addr >= 25.
